// File: rtl/hazard_controller.sv
// Decode-stage hazard sequencer: load scoreboard, RAW/full/fence stalls and branch flush control.
// Pipeline control outputs are combinational from inputs plus state; state updates on clk when clk_en=1.
module hazard_controller #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned FLUSH_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    input  logic        id_is_load,
    input  logic        id_is_fence,
    input  logic        ex_branch_taken,
    input  logic        wb_load_done,
    input  logic [4:0]  wb_rd,
    output logic        if_stall,
    output logic        id_stall,
    output logic        id_flush,
    output logic        ex_bubble,
    output logic        id_fire,
    output logic [31:0] busy_vec,
    output logic        sb_err
);

    localparam int unsigned OW          = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] CNT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [2:0]    FC_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit            MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          sb_err_q, sb_err_d;

    logic hz1_c, hz2_c, raw_c, full_c, fwait_c;
    logic stall_c, flush_c, bubble_c, fire_c;
    logic load_fire_c, inc_c, dec_c;

    // A source register completing writeback this cycle is bypassed, so it does not stall.
    always_comb begin
        hz1_c   = id_rs1_used && (id_rs1 != 5'd0) && busy_q[id_rs1]
                  && !(wb_load_done && (wb_rd == id_rs1));
        hz2_c   = id_rs2_used && (id_rs2 != 5'd0) && busy_q[id_rs2]
                  && !(wb_load_done && (wb_rd == id_rs2));
        raw_c   = id_valid && (hz1_c || hz2_c);
        full_c  = id_valid && id_is_load && (cnt_q == CNT_MAX) && !wb_load_done;
        fwait_c = id_valid && id_is_fence
                  && !((cnt_q == '0) || ((cnt_q == OW'(1)) && wb_load_done));
    end

    // Sequencer: branch flush > fence drain > RAW/full stall > fire.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        fire_c   = 1'b0;
        if (ex_branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            fcnt_d   = FC_RELOAD;
            state_d  = MULTI_FLUSH ? FLUSH : RUN;
        end else begin
            case (state_q)
                FLUSH: begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (fcnt_q != 3'd0) fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) state_d = RUN;
                end
                DRAIN: begin
                    if (fwait_c) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end else begin
                        fire_c  = id_valid;
                        state_d = RUN;
                    end
                end
                default: begin
                    if (fwait_c) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        state_d  = DRAIN;
                    end else if (raw_c || full_c) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end else begin
                        fire_c = id_valid;
                    end
                end
            endcase
        end
    end

    // Scoreboard and outstanding-load counter; a same-cycle set beats the clear.
    always_comb begin
        load_fire_c = fire_c && id_is_load;
        busy_d      = busy_q;
        if (wb_load_done) busy_d[wb_rd] = 1'b0;
        if (load_fire_c && id_rd_we && (id_rd != 5'd0)) busy_d[id_rd] = 1'b1;
        busy_d[0]   = 1'b0;

        inc_c    = load_fire_c;
        dec_c    = wb_load_done && (cnt_q != '0);
        cnt_d    = cnt_q;
        if (inc_c && !dec_c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + OW'(1);
        else if (dec_c && !inc_c)                  cnt_d = cnt_q - OW'(1);
        sb_err_d = sb_err_q || (wb_load_done && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            fcnt_q   <= 3'd0;
            busy_q   <= 32'd0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Everything reads as zero while reset is held.
    always_comb begin
        if_stall  = !rst && stall_c;
        id_stall  = !rst && stall_c;
        id_flush  = !rst && flush_c;
        ex_bubble = !rst && bubble_c;
        id_fire   = !rst && fire_c;
        busy_vec  = rst ? 32'd0 : busy_q;
        sb_err    = !rst && sb_err_q;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MAX_OUTSTANDING=4, FLUSH_CYCLES=3) with hand-computed expectations.
module tb_hazard_controller;

    logic        clk, rst, clk_en;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_fence;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_branch_taken, wb_load_done;
    logic        if_stall, id_stall, id_flush, ex_bubble, id_fire, sb_err;
    logic [31:0] busy_vec;
    logic [4:0]  ctl;

    int n_chk = 0;
    int n_err = 0;

    // ctl = {if_stall, id_stall, id_flush, ex_bubble, id_fire}
    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_FIRE  = 5'b00001;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00110;

    hazard_controller #(.MAX_OUTSTANDING(4), .FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_fence(id_is_fence),
        .ex_branch_taken(ex_branch_taken), .wb_load_done(wb_load_done), .wb_rd(wb_rd),
        .if_stall(if_stall), .id_stall(id_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
        .id_fire(id_fire), .busy_vec(busy_vec), .sb_err(sb_err)
    );

    assign ctl = {if_stall, id_stall, id_flush, ex_bubble, id_fire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fn, input logic br,
                       input logic wb, input logic [4:0] wrd);
        id_valid = v;   id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd;     id_rd_we = we; id_is_load = ld; id_is_fence = fn;
        ex_branch_taken = br; wb_load_done = wb; wb_rd = wrd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic load(input logic [4:0] rd);
        drv(1, 5'd0, 0, 5'd0, 0, rd, 1, 1, 0, 0, 0, 5'd0);
    endtask

    task automatic fence(input logic br, input logic wb, input logic [4:0] wrd);
        drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, br, wb, wrd);
    endtask

    logic [4:0] drain_rd [4] = '{5'd2, 5'd3, 5'd4, 5'd7};

    initial begin
        // Reset holds outputs at zero even with active-looking inputs
        rst = 1'b1; clk_en = 1'b1;
        drv(1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 1, 1, 1, 1, 5'd3);
        check("rst_ctl", 32'(ctl), 32'(C_IDLE));
        check("rst_busy", busy_vec, 32'h0);
        check("rst_err", 32'(sb_err), 32'd0);
        tick(); tick();
        rst = 1'b0;
        idle();
        check("post_rst_ctl", 32'(ctl), 32'(C_IDLE));
        check("post_rst_err", 32'(sb_err), 32'd0);

        // Load x5 then dependent add stalls until writeback bypass
        load(5'd5);
        check("t1_ld", 32'(ctl), 32'(C_FIRE));
        tick();
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0, 5'd0);
        check("t1_busy", busy_vec, 32'h0000_0020);
        check("t1_raw", 32'(ctl), 32'(C_STALL));
        tick();
        check("t1_raw2", 32'(ctl), 32'(C_STALL));
        tick();
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 1, 5'd5);
        check("t1_bypass", 32'(ctl), 32'(C_FIRE));
        tick();
        idle();
        check("t1_clr", busy_vec, 32'h0);

        // x0 source/dest never hazards but the load still counts
        drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0, 5'd0);
        check("t5_x0", 32'(ctl), 32'(C_FIRE));
        tick();
        idle();
        check("t5_busy", busy_vec, 32'h0);
        fence(0, 0, 5'd0);
        check("t5_fence", 32'(ctl), 32'(C_STALL));
        tick();
        fence(0, 1, 5'd0);
        check("t5_cnt", 32'(ctl), 32'(C_FIRE));
        tick();
        idle();
        check("t5_bit0", busy_vec, 32'h0);

        // Fill the load queue, then full stall and writeback release
        for (int i = 1; i <= 4; i++) begin
            load(5'(i));
            check("t2_ld", 32'(ctl), 32'(C_FIRE));
            tick();
        end
        load(5'd7);
        check("t2_full", 32'(ctl), 32'(C_STALL));
        check("t2_busy", busy_vec, 32'h0000_001E);
        tick();
        drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 1, 5'd1);
        check("t2_wbfull", 32'(ctl), 32'(C_FIRE));
        tick();
        load(5'd8);
        check("t2_busy2", busy_vec, 32'h0000_009C);
        check("t2_cnt4", 32'(ctl), 32'(C_STALL));
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, drain_rd[i]);
            tick();
        end
        idle();
        check("t2_empty", busy_vec, 32'h0);

        // Branch overrides RAW stall; flush holds for three cycles
        load(5'd9);
        tick();
        drv(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0, 0, 5'd0);
        check("t3_raw", 32'(ctl), 32'(C_STALL));
        tick();
        drv(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0, 1, 0, 5'd0);
        check("t3_flush1", 32'(ctl), 32'(C_FLUSH));
        tick();
        drv(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0, 0, 5'd0);
        check("t3_flush2", 32'(ctl), 32'(C_FLUSH));
        tick();
        check("t3_flush3", 32'(ctl), 32'(C_FLUSH));
        tick();
        check("t3_run", 32'(ctl), 32'(C_STALL));
        tick();
        drv(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0, 1, 5'd9);
        check("t3_release", 32'(ctl), 32'(C_FIRE));
        tick();

        // Fence drains two loads, fires on the second completion
        load(5'd10); tick();
        load(5'd11); tick();
        fence(0, 0, 5'd0);
        check("t4_fence", 32'(ctl), 32'(C_STALL));
        tick();
        check("t4_drain", 32'(ctl), 32'(C_STALL));
        tick();
        fence(0, 1, 5'd10);
        check("t4_wb1", 32'(ctl), 32'(C_STALL));
        tick();
        fence(0, 1, 5'd11);
        check("t4_wb2", 32'(ctl), 32'(C_FIRE));
        tick();
        load(5'd12);
        check("t4_ld12", 32'(ctl), 32'(C_FIRE));
        tick();
        drv(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0, 0, 0, 5'd0);
        check("t4_back_run", 32'(ctl), 32'(C_STALL));
        tick();
        // Branch mid-drain kills the fence
        fence(0, 0, 5'd0);
        check("t4_fence2", 32'(ctl), 32'(C_STALL));
        tick();
        fence(1, 0, 5'd0);
        check("t4_br", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle();
        check("t4_fl2", 32'(ctl), 32'(C_FLUSH));
        tick();
        check("t4_fl3", 32'(ctl), 32'(C_FLUSH));
        tick();
        check("t4_killed", 32'(ctl), 32'(C_IDLE));
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, 5'd12);
        tick();

        // Spurious writeback sets sticky error
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, 5'd3);
        check("t6_err0", 32'(sb_err), 32'd0);
        tick();
        idle();
        check("t6_err", 32'(sb_err), 32'd1);
        tick();
        check("t6_sticky", 32'(sb_err), 32'd1);

        // clk_en=0 freezes the scoreboard
        clk_en = 1'b0;
        load(5'd13);
        check("t6_frz_fire", 32'(ctl), 32'(C_FIRE));
        tick();
        idle();
        check("t6_frz_set", busy_vec, 32'h0);
        clk_en = 1'b1;
        load(5'd13);
        tick();
        clk_en = 1'b0;
        drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, 5'd13);
        tick();
        idle();
        check("t6_frz_clr", busy_vec, 32'h0000_2000);
        clk_en = 1'b1;

        // Reset mid-drain clears everything
        fence(0, 0, 5'd0);
        check("t6_fence", 32'(ctl), 32'(C_STALL));
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_ctl", 32'(ctl), 32'(C_IDLE));
        check("t6_rst_busy", busy_vec, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_fence", 32'(ctl), 32'(C_FIRE));
        check("t6_rst_err", 32'(sb_err), 32'd0);
        check("t6_rst_busy2", busy_vec, 32'h0);
        tick();
        drv(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 0, 0, 0, 0, 5'd0);
        check("t6_rst_sb", 32'(ctl), 32'(C_FIRE));
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
